// File: rtl/mandelbrot_pixel_packer.sv
// rtl/mandelbrot_pixel_packer.sv - buffers finished mandelbrot pixels and streams them as MS-first nibbles
// Holds a small pixel queue and the top-level nibble sequencer.

module mandelbrot_pixel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Callers only push when not full and only pop when non-empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head = mem[rd_ptr];
    assign full = (level == LW'(DEPTH));
endmodule

module mandelbrot_pixel_packer #(
    parameter int CTRWIDTH = 7,
    parameter int DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CTRWIDTH-1:0]        ctr_in,
    input  logic                       ctr_valid,
    input  logic [CTRWIDTH-1:0]        max_ctr,
    input  logic                       out_ready,
    input  logic                       clear_ovf,
    output logic [3:0]                 out_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic                       out_inset,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int NIBBLES = (CTRWIDTH + 3) / 4;
    localparam int PW      = 4 * NIBBLES;
    localparam int NW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int LW      = $clog2(DEPTH) + 1;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_SEND  = 1'b1
    } state_t;

    state_t              state;
    logic [NW-1:0]       nib_idx;
    logic                fifo_full;
    logic [CTRWIDTH:0]   head;
    logic [CTRWIDTH:0]   entry;
    logic                accept;
    logic                drop;
    logic                xfer;
    logic                last_nib;
    logic                pop;
    logic [PW-1:0]       padded;
    logic [3:0]          sel_nib;

    assign entry    = {(ctr_in == max_ctr), ctr_in};
    assign accept   = ctr_valid && !fifo_full;
    assign drop     = ctr_valid && fifo_full;
    assign xfer     = out_valid && out_ready;
    assign last_nib = (nib_idx == NW'(NIBBLES - 1));
    assign pop      = xfer && last_nib;

    mandelbrot_pixel_fifo #(
        .WIDTH (CTRWIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (entry),
        .pop       (pop),
        .head      (head),
        .level     (level),
        .full      (fifo_full)
    );

    // Fullness is judged on the registered level, so a same-cycle pop never
    // makes room for a push arriving while full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_EMPTY;
            nib_idx  <= '0;
            overflow <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            case (state)
                S_EMPTY: begin
                    nib_idx <= '0;
                    if (accept) begin
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (xfer) begin
                        nib_idx <= last_nib ? '0 : nib_idx + NW'(1);
                    end
                    if (pop && level == LW'(1) && !accept) begin
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign padded = PW'(head[CTRWIDTH-1:0]);

    always_comb begin
        sel_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_idx == NW'(i)) begin
                sel_nib = padded[4*(NIBBLES-1-i) +: 4];
            end
        end
    end

    assign out_valid = (state == S_SEND);
    assign out_data  = out_valid ? sel_nib : 4'h0;
    assign out_last  = out_valid && last_nib;
    assign out_inset = out_valid && head[CTRWIDTH];
endmodule
